// File: rtl/cmd_ack_encoder.sv
// cmd_ack_encoder: serialises command acknowledges into fixed 60-byte Ethernet frames on an 8-bit AXI-Stream master
module cmd_ack_encoder #(
  parameter logic [47:0] HOST_MAC_ADDR = 48'h985aebdb066f,
  parameter logic [47:0] FPGA_MAC_ADDR = 48'h5a0102030405,
  parameter logic [15:0] ETH_LEN       = 16'h0022,
  parameter int          IFG_CYCLES    = 12
) (
  input  logic        gtx_clk_bufg,
  input  logic        gtx_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_cmd_tag,
  input  logic [31:0] req_cmd_id,
  input  logic [31:0] req_status,
  input  logic [63:0] req_data,
  output logic [7:0]  tx_axis_tdata,
  output logic        tx_axis_tvalid,
  output logic        tx_axis_tlast,
  input  logic        tx_axis_tready,
  output logic [7:0]  seq_num,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t      state, state_d;
  logic [5:0]  cnt, cnt_d;
  logic [7:0]  gap, gap_d, seq_d, byte_d;
  logic [31:0] tag, id, status, id_sw, status_sw;
  logic [63:0] data, data_sw;
  logic [287:0] hdr, hdr_sh;
  logic        beat, take;
  assign beat = tx_axis_tvalid & tx_axis_tready;
  assign take = req_valid & req_ready;
  assign id_sw = {<<8{id}};
  assign status_sw = {<<8{status}};
  assign data_sw = {<<8{data}};
  assign hdr = {HOST_MAC_ADDR, FPGA_MAC_ADDR, ETH_LEN, seq_num, 8'h00, tag, id_sw, status_sw, data_sw};
  // shifting past the 36 header bytes leaves zeros, which is exactly the pad
  assign hdr_sh = hdr << {cnt_d, 3'b000};
  assign byte_d = hdr_sh[287:280];
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    gap_d = gap;
    seq_d = seq_num;
    case (state)
      IDLE: if (take) begin
        state_d = SEND;
        cnt_d = '0;
      end
      SEND: if (beat) begin
        if (cnt == 6'd59) begin
          seq_d = seq_num + 8'd1;
          gap_d = '0;
          state_d = (IFG_CYCLES == 0) ? IDLE : GAP;
        end else cnt_d = cnt + 6'd1;
      end
      GAP: begin
        gap_d = gap + 8'd1;
        state_d = (gap == 8'(IFG_CYCLES - 1)) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
    if (!gtx_resetn) begin
      state <= IDLE;
      cnt <= '0;
      gap <= '0;
      seq_num <= '0;
      tag <= '0;
      id <= '0;
      status <= '0;
      data <= '0;
      req_ready <= 1'b0;
      busy <= 1'b0;
      tx_axis_tvalid <= 1'b0;
      tx_axis_tlast <= 1'b0;
      tx_axis_tdata <= 8'h00;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      gap <= gap_d;
      seq_num <= seq_d;
      if (take) begin
        tag <= req_cmd_tag;
        id <= req_cmd_id;
        status <= req_status;
        data <= req_data;
      end
      req_ready <= state_d == IDLE;
      busy <= state_d != IDLE;
      tx_axis_tvalid <= state_d == SEND;
      tx_axis_tlast <= (state_d == SEND) && (cnt_d == 6'd59);
      tx_axis_tdata <= (state_d == SEND) ? byte_d : 8'h00;
    end
  end
endmodule

// File: tb/tb_cmd_ack_encoder.sv
// tb_cmd_ack_encoder: directed self-checking bench for cmd_ack_encoder
module tb_cmd_ack_encoder;
  localparam logic [47:0] HOST = 48'h985aebdb066f;
  localparam logic [47:0] FPGA = 48'h5a0102030405;
  localparam logic [15:0] LEN  = 16'h0022;
  logic        gtx_clk_bufg = 1'b0;
  logic        gtx_resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_cmd_tag = '0, req_cmd_id = '0, req_status = '0;
  logic [63:0] req_data = '0;
  logic [7:0]  tx_axis_tdata;
  logic        tx_axis_tvalid, tx_axis_tlast;
  logic        tx_axis_tready = 1'b1;
  logic [7:0]  seq_num;
  logic        busy;
  int checks = 0, errors = 0;
  logic [7:0] rx [60];
  logic       rx_last [60];
  int rx_cycles, hold_bad, ready_seen, got;
  logic [7:0] basic_hdr [36] = '{8'h98, 8'h5a, 8'heb, 8'hdb, 8'h06, 8'h6f, 8'h5a, 8'h01, 8'h02,
    8'h03, 8'h04, 8'h05, 8'h00, 8'h22, 8'h00, 8'h00, 8'h46, 8'h46, 8'h57, 8'h57, 8'hfc, 8'h17,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

  cmd_ack_encoder #(.IFG_CYCLES(12)) dut (
    .gtx_clk_bufg(gtx_clk_bufg), .gtx_resetn(gtx_resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd_tag(req_cmd_tag), .req_cmd_id(req_cmd_id), .req_status(req_status), .req_data(req_data),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tlast(tx_axis_tlast),
    .tx_axis_tready(tx_axis_tready), .seq_num(seq_num), .busy(busy)
  );

  always #5 gtx_clk_bufg = ~gtx_clk_bufg;

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_byte(int k, logic [7:0] s, logic [31:0] t, logic [31:0] i,
                                          logic [31:0] st, logic [63:0] d);
    logic [7:0] b;
    b = 8'h00;
    if (k < 6) b = HOST[8*(5-k) +: 8];
    else if (k < 12) b = FPGA[8*(11-k) +: 8];
    else if (k < 14) b = LEN[8*(13-k) +: 8];
    else if (k == 14) b = s;
    else if (k < 16) b = 8'h00;
    else if (k < 20) b = t[8*(19-k) +: 8];
    else if (k < 24) b = i[8*(k-20) +: 8];
    else if (k < 28) b = st[8*(k-24) +: 8];
    else if (k < 36) b = d[8*(k-28) +: 8];
    return b;
  endfunction

  task automatic step();
    @(posedge gtx_clk_bufg);
    #1;
  endtask

  task automatic do_reset();
    gtx_resetn = 1'b0;
    step();
    gtx_resetn = 1'b1;
    step();
    step();
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300 && !req_ready; c++) step();
  endtask

  task automatic send_req(input logic [31:0] t, input logic [31:0] i, input logic [31:0] s,
                          input logic [63:0] d, input bit keep, output bit ok);
    req_cmd_tag = t;
    req_cmd_id = i;
    req_status = s;
    req_data = d;
    req_valid = 1'b1;
    ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (req_ready) ok = 1;
      step();
    end
    if (!keep) req_valid = 1'b0;
  endtask

  // receives one frame, stalling len cycles when byte s1 or s2 is presented
  task automatic collect(input int s1, input int s2, input int len);
    int k, sc;
    logic [7:0] hd;
    logic hl;
    k = 0;
    sc = 0;
    hd = 8'h00;
    hl = 1'b0;
    rx_cycles = 0;
    hold_bad = 0;
    ready_seen = 0;
    while (k < 60 && rx_cycles < 500) begin
      if (req_ready) ready_seen++;
      if ((k == s1 || k == s2) && sc < len) begin
        tx_axis_tready = 1'b0;
        if (!tx_axis_tvalid) hold_bad++;
        if (sc == 0) begin
          hd = tx_axis_tdata;
          hl = tx_axis_tlast;
        end else if (tx_axis_tdata !== hd || tx_axis_tlast !== hl) hold_bad++;
        sc++;
      end else begin
        tx_axis_tready = 1'b1;
        if (tx_axis_tvalid) begin
          rx[k] = tx_axis_tdata;
          rx_last[k] = tx_axis_tlast;
          k++;
          sc = 0;
        end else hold_bad++;
      end
      step();
      rx_cycles++;
    end
    tx_axis_tready = 1'b1;
    got = k;
  endtask

  task automatic test_reset();
    gtx_resetn = 1'b0;
    step();
    step();
    checks++; if (tx_axis_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h exp 00", tx_axis_tdata); end
    checks++; if (tx_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", tx_axis_tvalid); end
    checks++; if (tx_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", tx_axis_tlast); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready); end
    checks++; if (seq_num !== 8'h00) begin errors++; $display("FAIL reset_seq got %h exp 00", seq_num); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    gtx_resetn = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b exp 0", req_ready); end
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge got %b exp 1", req_ready); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] e;
    send_req(32'h46465757, 32'h000017fc, 32'h0, 64'h0102030405060708, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_accept got timeout exp handshake"); end
    checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_hs_flags got ready=%b busy=%b exp 0 1", req_ready, busy); end
    checks++; if (tx_axis_tvalid !== 1'b1 || tx_axis_tdata !== 8'h98) begin errors++; $display("FAIL basic_byte0 got v=%b d=%h exp 1 98", tx_axis_tvalid, tx_axis_tdata); end
    collect(-1, -1, 0);
    checks++; if (got !== 60 || rx_cycles !== 60) begin errors++; $display("FAIL basic_len got bytes=%0d cycles=%0d exp 60 60", got, rx_cycles); end
    for (int k = 0; k < 60; k++) begin
      e = (k < 36) ? basic_hdr[k] : 8'h00;
      checks++; if (rx[k] !== e) begin errors++; $display("FAIL basic_byte%0d got %h exp %h", k, rx[k], e); end
    end
    for (int k = 0; k < 59; k++) begin
      checks++; if (rx_last[k] !== 1'b0) begin errors++; $display("FAIL basic_early_tlast byte %0d got 1 exp 0", k); end
    end
    checks++; if (rx_last[59] !== 1'b1) begin errors++; $display("FAIL basic_tlast59 got %b exp 1", rx_last[59]); end
    checks++; if (tx_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_tvalid_after got %b exp 0", tx_axis_tvalid); end
    checks++; if (seq_num !== 8'h01) begin errors++; $display("FAIL basic_seq got %h exp 01", seq_num); end
    wait_idle();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] e;
    send_req(32'hcafef00d, 32'h89abcdef, 32'h00000005, 64'h1122334455667788, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept got timeout exp handshake"); end
    collect(20, 59, 5);
    checks++; if (got !== 60 || rx_cycles !== 70) begin errors++; $display("FAIL bp_len got bytes=%0d cycles=%0d exp 60 70", got, rx_cycles); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold got %0d violations exp 0", hold_bad); end
    for (int k = 0; k < 60; k++) begin
      e = exp_byte(k, 8'h01, 32'hcafef00d, 32'h89abcdef, 32'h00000005, 64'h1122334455667788);
      checks++; if (rx[k] !== e) begin errors++; $display("FAIL bp_byte%0d got %h exp %h", k, rx[k], e); end
    end
    checks++; if (rx_last[59] !== 1'b1 || rx_last[58] !== 1'b0) begin errors++; $display("FAIL bp_tlast got %b%b exp 01", rx_last[58], rx_last[59]); end
    checks++; if (seq_num !== 8'h02) begin errors++; $display("FAIL bp_seq got %h exp 02", seq_num); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] e;
    send_req(32'h46465757, 32'h00000001, 32'h0, 64'h0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_accept got timeout exp handshake"); end
    for (int c = 0; c < 30; c++) step();
    checks++; if (tx_axis_tvalid !== 1'b1) begin errors++; $display("FAIL rm_midframe_valid got %b exp 1", tx_axis_tvalid); end
    #2;
    gtx_resetn = 1'b0;
    #1;
    checks++; if (tx_axis_tvalid !== 1'b0 || tx_axis_tlast !== 1'b0) begin errors++; $display("FAIL rm_async got v=%b l=%b exp 0 0", tx_axis_tvalid, tx_axis_tlast); end
    checks++; if (seq_num !== 8'h00) begin errors++; $display("FAIL rm_seq got %h exp 00", seq_num); end
    checks++; if (busy !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rm_flags got busy=%b ready=%b exp 0 0", busy, req_ready); end
    step();
    gtx_resetn = 1'b1;
    step();
    send_req(32'h01020304, 32'h0a0b0c0d, 32'hffffffff, 64'hfedcba9876543210, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_reaccept got timeout exp handshake"); end
    collect(-1, -1, 0);
    checks++; if (got !== 60) begin errors++; $display("FAIL rm_len got %0d exp 60", got); end
    for (int k = 0; k < 60; k++) begin
      e = exp_byte(k, 8'h00, 32'h01020304, 32'h0a0b0c0d, 32'hffffffff, 64'hfedcba9876543210);
      checks++; if (rx[k] !== e) begin errors++; $display("FAIL rm_byte%0d got %h exp %h", k, rx[k], e); end
    end
    checks++; if (rx_last[59] !== 1'b1) begin errors++; $display("FAIL rm_tlast got %b exp 1", rx_last[59]); end
    wait_idle();
  endtask

  task automatic test_input_change();
    bit ok;
    logic [7:0] e;
    send_req(32'h46465757, 32'h11223344, 32'h55667788, 64'h0011223344556677, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ic_accept got timeout exp handshake"); end
    req_cmd_id = 32'hdeadbeef;
    req_cmd_tag = 32'h0;
    req_status = 32'h0;
    req_data = 64'hffffffffffffffff;
    collect(-1, -1, 0);
    checks++; if (got !== 60) begin errors++; $display("FAIL ic_len got %0d exp 60", got); end
    for (int k = 0; k < 60; k++) begin
      e = exp_byte(k, 8'h01, 32'h46465757, 32'h11223344, 32'h55667788, 64'h0011223344556677);
      checks++; if (rx[k] !== e) begin errors++; $display("FAIL ic_byte%0d got %h exp %h", k, rx[k], e); end
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int gap;
    do_reset();
    send_req(32'h46465757, 32'h00000042, 32'h0, 64'h0, 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_accept got timeout exp handshake"); end
    for (int f = 0; f < 3; f++) begin
      collect(-1, -1, 0);
      checks++; if (got !== 60 || rx_cycles !== 60) begin errors++; $display("FAIL b2b_len frame %0d got bytes=%0d cycles=%0d exp 60 60", f, got, rx_cycles); end
      checks++; if (rx[14] !== 8'(f)) begin errors++; $display("FAIL b2b_seq frame %0d got %h exp %h", f, rx[14], 8'(f)); end
      checks++; if (rx[20] !== 8'h42 || rx_last[59] !== 1'b1) begin errors++; $display("FAIL b2b_content frame %0d got id=%h last=%b exp 42 1", f, rx[20], rx_last[59]); end
      checks++; if (ready_seen !== 0) begin errors++; $display("FAIL b2b_ready_in_frame frame %0d got %0d cycles high exp 0", f, ready_seen); end
      if (f < 2) begin
        gap = 0;
        while (!req_ready && gap < 100) begin
          step();
          gap++;
        end
        checks++; if (gap !== 12) begin errors++; $display("FAIL b2b_gap frame %0d got %0d exp 12", f, gap); end
        step();
      end
    end
    req_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_seq_wrap();
    bit ok;
    int bad;
    do_reset();
    bad = 0;
    for (int f = 1; f <= 257; f++) begin
      send_req(32'h46465757, 32'(f), 32'h0, 64'h0, 0, ok);
      if (!ok) bad++;
      collect(-1, -1, 0);
      if (got != 60) bad++;
      if (f == 256) begin
        checks++; if (rx[14] !== 8'hff) begin errors++; $display("FAIL wrap_frame256 got %h exp ff", rx[14]); end
      end
      if (f == 257) begin
        checks++; if (rx[14] !== 8'h00) begin errors++; $display("FAIL wrap_frame257 got %h exp 00", rx[14]); end
      end
      wait_idle();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_frames got %0d bad frames exp 0", bad); end
    checks++; if (seq_num !== 8'h01) begin errors++; $display("FAIL wrap_seq_after got %h exp 01", seq_num); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_input_change();
    test_back_to_back();
    test_seq_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmd_ack_encoder.md
# cmd_ack_encoder

Command acknowledge frame generator for the host command link. Sits on the FPGA transmit side, opposite the command decoder. The decoder requests an acknowledge for each command it has parsed, carrying the command tag, id, status and a 64-bit data word. This block serialises the acknowledge into a fixed 60-byte Ethernet frame on an 8-bit AXI-Stream master toward the MAC tx FIFO.

## Interface
Parameters:
- HOST_MAC_ADDR, 48'h985aebdb066f: destination MAC, sent MSB byte first.
- FPGA_MAC_ADDR, 48'h5a0102030405: source MAC, sent MSB byte first.
- ETH_LEN, 16'h0022: length/type field, sent MSB byte first.
- IFG_CYCLES, 12: idle cycles enforced after each frame; range 0–255.

Ports:
- gtx_clk_bufg  in  1  sole clock; all logic on its rising edge.
- gtx_resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  acknowledge request valid.
- req_ready  out  1  block can accept a request.
- req_cmd_tag  in  32  command tag, e.g. 32'h46465757 ("FFWW").
- req_cmd_id  in  32  command id echoed to the host.
- req_status  in  32  status word.
- req_data  in  64  response data.
- tx_axis_tdata  out  8  frame byte.
- tx_axis_tvalid  out  1  byte valid.
- tx_axis_tlast  out  1  last byte of frame.
- tx_axis_tready  in  1  downstream accepts byte.
- seq_num  out  8  sequence number of the next frame to send.
- busy  out  1  high in SEND or GAP.

## Operation
- Frame layout, bytes 0–59:
  - 0–5: HOST_MAC_ADDR.
  - 6–11: FPGA_MAC_ADDR.
  - 12–13: ETH_LEN.
  - 14: seq_num.
  - 15: 8'h00.
  - 16–19: req_cmd_tag, MSB first.
  - 20–23: req_cmd_id, LSB first.
  - 24–27: req_status, LSB first.
  - 28–35: req_data, LSB first.
  - 36–59: 8'h00 pad.
- States:
  - IDLE: req_ready=1. A request handshake (req_valid & req_ready) latches all req_* fields and seq_num, then goes to SEND.
  - SEND: a 6-bit byte counter 0..59 advances only on tvalid & tready. A handshake on byte 59 goes to GAP, or to IDLE if IFG_CYCLES=0.
  - GAP: an 8-bit counter runs IFG_CYCLES cycles, then goes to IDLE.
- seq_num increments by 1 on each handshake of byte 59 and wraps 255→0.
- Request fields are captured at the handshake. Input changes after capture do not affect the frame in flight.
- req_valid while not IDLE is ignored: no queueing and no loss of the held request. The requester keeps req_valid high until req_ready.
- AXI-Stream rules:
  - Once tvalid=1, tdata and tlast hold stable until tready=1.
  - tvalid never drops mid-frame.
  - tlast=1 only on byte 59.
- Reset, including mid-frame: all outputs and state clear immediately, the frame is abandoned with no tlast, and seq_num returns to 0.

## Timing
- Reset values:
  - tx_axis_tdata=8'h00, tx_axis_tvalid=0, tx_axis_tlast=0.
  - req_ready=0, seq_num=0, busy=0, state=IDLE.
- req_ready is registered. It rises on the first clock edge after gtx_resetn deasserts.
- All outputs are registered; nothing is combinational from inputs.
- Request handshake at edge N:
  - req_ready=0 and busy=1 after edge N.
  - Byte 0 is presented with tvalid=1 after edge N.
- With tready held at 1:
  - Byte k is accepted at edge N+1+k.
  - tlast is accepted at edge N+60.
  - tvalid=0 after edge N+60.
  - req_ready=1 after edge N+60+IFG_CYCLES.
- Request throughput with tready=1 is one frame per 61+IFG_CYCLES cycles.
- A tready=0 stall of S cycles delays every later event by exactly S cycles. The presented byte is unchanged during the stall.

## Test plan
- **Basic frame:** after reset, req tag=32'h46465757, id=32'h000017fc, status=0, data=64'h0102030405060708, tready=1. Check:
  - 60 bytes: 98 5a eb db 06 6f 5a 01 02 03 04 05 00 22 00 00 46 46 57 57 fc 17 00 00 00 00 00 00 08 07 06 05 04 03 02 01, then 24×00.
  - tlast on byte 59.
  - seq_num=1 afterwards.
- **Backpressure:** tready low for 5 cycles at byte 20 and again at byte 59. Check that tdata and tlast hold during each stall, no byte is duplicated or dropped, and total frame time is 60+10 cycles.
- **Back-to-back:** req_valid held high for 3 requests with IFG_CYCLES=12. Check:
  - Three frames with seq bytes 00, 01, 02.
  - Exactly 12 idle cycles between each frame's last beat and the next request acceptance.
  - req_ready=0 throughout each frame.
- **Sequence wrap:** 257 requests. Check that byte 14 of frame 256 is 8'hff and of frame 257 is 8'h00.
- **Reset mid-frame:** assert gtx_resetn=0 at byte 30, without waiting for a clock edge. Check:
  - tvalid=0 and tlast=0 immediately.
  - seq_num=0.
  - After release, a new request produces a complete frame starting at byte 0 with seq byte 00.
- **Input change after capture:** change req_cmd_id one cycle after the handshake. Check that the frame carries the originally captured value.
